riscv_mem_responder: RTL and testbench

//  Single-port memory responder: the slave end of the core's val/rdy memory request/response

---
 rtl/riscv_mem_responder.sv | 120 ++++++++++++
 tb/tb_riscv_mem_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_responder.sv
`default_nettype none
// ============================================================================
// riscv_mem_responder : val/rdy word-array memory slave, one request in flight
// Revision: 1.0
// ============================================================================
module riscv_mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [66:0] memreq_msg,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  output logic [34:0] memresp_msg,
  output logic        memresp_val
);

  localparam int         AW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [3:0]  wait_cnt;
  logic [34:0] pend_msg;
  logic [31:0] mem [MEM_WORDS];

  logic        req_type;
  logic [31:0] req_addr;
  logic [1:0]  req_len;
  logic [31:0] req_data;
  logic [AW-1:0] idx;
  logic [1:0]  off;
  logic        accept;

  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] len_mask;
  logic [31:0] rd_data;
  logic [3:0]  be_base;
  logic [3:0]  be;
  logic [31:0] wr_data;
  logic [34:0] new_msg;
  logic        unused_addr;

  assign req_type = memreq_msg[66];
  assign req_addr = memreq_msg[65:34];
  assign req_len  = memreq_msg[33:32];
  assign req_data = memreq_msg[31:0];
  assign idx      = req_addr[AW+1:2];
  assign off      = req_addr[1:0];
  assign accept   = memreq_val && memreq_rdy;
  assign unused_addr = ^req_addr[31:AW+2];

  // Lane alignment: request byte 0 lands on lane 'off'; lanes past 3 fall off the word
  always_comb begin
    rd_word  = mem[idx];
    rd_shift = rd_word >> {off, 3'b000};
    case (req_len)
      2'd1:    begin len_mask = 32'h0000_00FF; be_base = 4'h1; end
      2'd2:    begin len_mask = 32'h0000_FFFF; be_base = 4'h3; end
      2'd3:    begin len_mask = 32'h00FF_FFFF; be_base = 4'h7; end
      default: begin len_mask = 32'hFFFF_FFFF; be_base = 4'hF; end
    endcase
    rd_data = rd_shift & len_mask;
    be      = be_base << off;
    wr_data = req_data << {off, 3'b000};
    new_msg = req_type ? {1'b1, req_len, 32'd0} : {1'b0, req_len, rd_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (LATENCY > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (wait_cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    memreq_rdy  = (state == S_IDLE);
    memresp_val = (state == S_RESP);
  end

  // The response message only changes on entry to RESP so it holds otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt    <= 4'd0;
      pend_msg    <= 35'd0;
      memresp_msg <= 35'd0;
    end else if (accept) begin
      wait_cnt <= LAT_M1;
      pend_msg <= new_msg;
      if (LATENCY == 0) memresp_msg <= new_msg;
    end else if (state == S_WAIT) begin
      if (wait_cnt == 4'd0) memresp_msg <= pend_msg;
      else                  wait_cnt    <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && reset && req_type) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_riscv_mem_responder : scoreboard bench, LATENCY=0 and LATENCY=3 instances
// Revision: 1.0
// ============================================================================
module tb_riscv_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [66:0] msg0, msg3;
  logic        val0, val3;
  logic        rdy0, rdy3;
  logic [34:0] rmsg0, rmsg3;
  logic        rval0, rval3;

  always #5 clk = ~clk;

  riscv_mem_responder #(.MEM_WORDS(1024), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .memreq_msg(msg0), .memreq_val(val0), .memreq_rdy(rdy0),
    .memresp_msg(rmsg0), .memresp_val(rval0)
  );

  riscv_mem_responder #(.MEM_WORDS(1024), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .memreq_msg(msg3), .memreq_val(val3), .memreq_rdy(rdy3),
    .memresp_msg(rmsg3), .memresp_val(rval3)
  );

  typedef struct {
    logic [34:0] msg;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  exp_t e0, e3;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rval0 === 1'b1) begin
      if (q0.size() == 0) check("dut0 unexpected resp", 64'(rval0), 64'd0);
      else begin
        e0 = q0.pop_front();
        check("dut0 resp msg", 64'(rmsg0), 64'(e0.msg));
        check("dut0 resp latency", 64'(cyc - e0.acc), 64'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (rval3 === 1'b1) begin
      if (q3.size() == 0) check("dut3 unexpected resp", 64'(rval3), 64'd0);
      else begin
        e3 = q3.pop_front();
        check("dut3 resp msg", 64'(rmsg3), 64'(e3.msg));
        check("dut3 resp latency", 64'(cyc - e3.acc), 64'd4);
      end
    end
  end

  // Leaves val asserted after the accepting edge so callers can chain requests
  task automatic issue(input bit d3, input bit typ, input logic [31:0] addr,
                       input logic [1:0] len, input logic [31:0] data,
                       input logic [31:0] exp_data, input bit push, output int acc);
    exp_t e;
    int   n;
    @(negedge clk);
    if (d3) begin msg3 = {typ, addr, len, data}; val3 = 1'b1; end
    else    begin msg0 = {typ, addr, len, data}; val0 = 1'b1; end
    n = 0;
    while (!(d3 ? rdy3 : rdy0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept timeout", 64'(d3 ? rdy3 : rdy0), 64'd1);
    acc   = cyc;
    e.msg = {typ, len, exp_data};
    e.acc = acc;
    if (push) begin
      if (d3) q3.push_back(e);
      else    q0.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    val0 = 1'b0;
    val3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, c;
    reset = 1'b0;
    val0 = 1'b0; val3 = 1'b0;
    msg0 = '0;   msg3 = '0;
    repeat (2) @(negedge clk);
    check("reset rdy0",  64'(rdy0),  64'd1);
    check("reset rdy3",  64'(rdy3),  64'd1);
    check("reset rval0", 64'(rval0), 64'd0);
    check("reset rval3", 64'(rval3), 64'd0);
    check("reset rmsg0", 64'(rmsg0), 64'd0);
    check("reset rmsg3", 64'(rmsg3), 64'd0);
    reset = 1'b1;

    // word write / read, byte write, partial write with lane overflow
    issue(0, 1, 32'h100, 2'd0, 32'hDEADBEEF, 32'h0,        1, a);
    issue(0, 0, 32'h100, 2'd0, 32'h0,        32'hDEADBEEF, 1, a);
    issue(0, 1, 32'h103, 2'd1, 32'h000000AA, 32'h0,        1, a);
    issue(0, 0, 32'h103, 2'd1, 32'h0,        32'h000000AA, 1, a);
    issue(0, 0, 32'h100, 2'd0, 32'h0,        32'hAAADBEEF, 1, a);
    issue(0, 1, 32'h102, 2'd3, 32'h00112233, 32'h0,        1, a);
    issue(0, 0, 32'h100, 2'd0, 32'h0,        32'h2233BEEF, 1, a);
    issue(0, 0, 32'h101, 2'd2, 32'h0,        32'h000033BE, 1, a);

    // address wrap modulo array size
    issue(0, 1, 32'h1000, 2'd0, 32'h12345678, 32'h0,        1, a);
    issue(0, 0, 32'h0,    2'd0, 32'h0,        32'h12345678, 1, a);
    issue(0, 0, 32'h3,    2'd2, 32'h0,        32'h00000012, 1, a);

    // back-to-back accepts every other cycle with val held
    issue(0, 0, 32'h0, 2'd1, 32'h0, 32'h00000078, 1, a);
    issue(0, 0, 32'h1, 2'd1, 32'h0, 32'h00000056, 1, b);
    issue(0, 0, 32'h2, 2'd3, 32'h0, 32'h00001234, 1, c);
    check("b2b spacing 1", 64'(b - a), 64'd2);
    check("b2b spacing 2", 64'(c - b), 64'd2);
    idle();

    // LATENCY=3 ready/valid timeline
    issue(1, 1, 32'h40, 2'd0, 32'hCAFEF00D, 32'h0, 1, a);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) val3 = 1'b0;
      check($sformatf("lat3 rdy +%0d", k),  64'(rdy3),  64'(k == 5));
      check($sformatf("lat3 rval +%0d", k), 64'(rval3), 64'(k == 4));
    end
    issue(1, 0, 32'h40, 2'd0, 32'h0, 32'hCAFEF00D, 1, a);
    idle();
    repeat (6) @(negedge clk);

    // reset while waiting: response dropped, write kept
    issue(1, 1, 32'h80, 2'd0, 32'h0BADCAFE, 32'h0, 0, a);
    @(negedge clk);
    val3 = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("in-reset rval3", 64'(rval3), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post-reset rdy3",  64'(rdy3),  64'd1);
    check("post-reset rval3", 64'(rval3), 64'd0);
    repeat (6) @(negedge clk);
    issue(1, 0, 32'h80, 2'd0, 32'h0, 32'h0BADCAFE, 1, a);
    issue(0, 0, 32'h0,  2'd0, 32'h0, 32'h12345678, 1, a);
    idle();

    repeat (10) @(negedge clk);
    check("q0 drained", 64'(q0.size()), 64'd0);
    check("q3 drained", 64'(q3.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
